pwm_capture: RTL
================

Name: pwm_capture

Overview:
- Servo-PWM decoder: the receive end of the servo pulse interface.
- Measures high-pulse width on a 50 MHz clock and converts it to a signed angle code (magnitude plus sign), in the same format the servo PWM driver consumes.
- Used for loopback checking of the driver and for reading external servo/RC signals into the accelerometer design.

Parameters:
- CENTER_CNT, 75_000: pulse width in clocks for angle 0.
- STEP_CNT, 390: clocks per angle LSB (50_000/128).
- MIN_CNT, 25_000: minimum legal width.
- MAX_CNT, 125_000: maximum legal width.
- TIMEOUT_CNT, 1_100_000: clocks with no rising edge before declaring loss of signal.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_a_n  in  1  asynchronous active-low reset.
- pwm_in  in  1  asynchronous servo PWM input.
- absolute_angle  out  16  angle magnitude, left-shifted by 1 (bits [8:1] hold 0..128; bit 0 and bits [15:9] are 0).
- is_negative  out  1  sign of the angle; 1 when width < CENTER_CNT.
- valid  out  1  one-cycle pulse when a new angle is published.
- range_err  out  1  one-cycle pulse, coincident with valid, when the width was outside MIN_CNT..MAX_CNT.
- timeout  out  1  level; 1 while no rising edge has been seen for TIMEOUT_CNT clocks.

Behaviour:
- Clocking and reset: one clock, clk; reset rst_a_n is asynchronous, active-low. All outputs reset to 0.
- Input conditioning: pwm_in passes through a 2-FF synchronizer plus edge detect. All edge references below are to the synchronized signal, which lags the pin by 2 clocks.
- FSM states:
  - SYNC: wait for sync low, then go to WAIT_RISE. Ignores a pulse already in progress at reset release.
  - WAIT_RISE: on rise, clear width_cnt and go to HIGH.
  - HIGH: width_cnt increments every clock while high; the counter saturates at 2^20-1. On fall, latch width_cnt and go to DIVIDE.
  - DIVIDE: compute diff = |width - CENTER_CNT| and neg = (width < CENTER_CNT).
    - If width < MIN_CNT or width > MAX_CNT, set magnitude = 128 and raise range_err.
    - Otherwise, magnitude = floor(diff / STEP_CNT) by repeated subtraction, one subtraction per clock. This is at most 129 clocks, with the result capped at 128.
    - Then go to PUBLISH.
  - PUBLISH: register absolute_angle = {7'b0, magnitude, 1'b0} and is_negative = neg. Force is_negative = 0 when magnitude = 0. Pulse valid for 1 clock, then go to WAIT_RISE.
- Latency: valid asserts at most 133 clocks after the falling edge at the pin.
- Edges during DIVIDE/PUBLISH: a rise during DIVIDE/PUBLISH is missed. The FSM returns to WAIT_RISE and waits for the next rise; this is legal because periods are far longer than the computation.
- Timeout:
  - An idle counter resets on every rise.
  - When it reaches TIMEOUT_CNT, timeout = 1 and the FSM returns to SYNC.
  - absolute_angle and is_negative hold their last values.
  - timeout clears on the next published valid.
- Mid-operation reset: aborts any measurement; no valid is issued for the interrupted pulse.
- Width arithmetic: 20-bit unsigned counters.

Optional Feature:
- Macro: PWM_CAPTURE_GLITCH_FILTER_EN.
- When defined: the synchronized input must be stable for 16 consecutive clocks before a level change is accepted. Pulses shorter than 16 clocks are ignored; measured widths are unchanged for clean input, and latency grows by 16 clocks.
- When undefined: the raw synchronized signal is used.

Decomposition:
- Shared package: CENTER_CNT, STEP_CNT, MIN_CNT, MAX_CNT, the PWM period constant (1_000_000), the angle magnitude width (8) and the FSM state enum. The same constants are also used by the servo PWM driver.
- One sub-module: pwm_edge_sync, containing the 2-FF synchronizer, the optional glitch filter, and the rise/fall pulse outputs.

Test Plan:
- Width 75_000, period 1_000_000 -> valid pulse, absolute_angle = 0, is_negative = 0, range_err = 0.
- Width 92_550 (75_000 + 45·390) -> absolute_angle = 90, is_negative = 0. Width 36_000 (75_000 − 100·390) -> absolute_angle = 200, is_negative = 1.
- Widths 125_000 and 25_000 -> absolute_angle = 256 (128<<1), sign 0/1 respectively, no range_err. Width 20_000 -> absolute_angle = 256, is_negative = 1, range_err pulses with valid.
- Hold pwm_in low for 1_200_000 clocks after a good pulse -> timeout = 1 at 1_100_000 clocks after the last rise, outputs hold. Next good pulse -> timeout = 0 and a new valid.
- Assert rst_a_n low mid-pulse, release while pwm_in is still high -> no valid for that pulse; the next full pulse decodes correctly.
- Drive the servo PWM driver's output into pwm_capture with the driver's input sweeping −128..+128 -> decoded {is_negative, absolute_angle[8:1]} matches within ±1 LSB (the ±1 covers the driver's truncated step constant).
- With PWM_CAPTURE_GLITCH_FILTER_EN defined, inject a 10-clock high glitch during the low phase -> no valid issued.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// Shared servo-PWM constants and capture FSM state encoding.
// Also used by the servo PWM driver so both ends agree on the pulse format.
package pwm_capture_pkg;

   localparam int unsigned PWM_CENTER_CNT  = 75_000;
   localparam int unsigned PWM_STEP_CNT    = 390;
   localparam int unsigned PWM_MIN_CNT     = 25_000;
   localparam int unsigned PWM_MAX_CNT     = 125_000;
   localparam int unsigned PWM_PERIOD_CNT  = 1_000_000;
   localparam int unsigned PWM_TIMEOUT_CNT = 1_100_000;
   localparam int unsigned ANGLE_W         = 8;
   localparam int unsigned CNT_W           = 20;
   localparam int unsigned IDLE_W          = 21;

   typedef enum logic [2:0] {
      ST_SYNC,
      ST_WAIT_RISE,
      ST_HIGH,
      ST_DIVIDE,
      ST_PUBLISH
   } state_t;

endpackage

// File: rtl/pwm_edge_sync.sv
// 2-FF synchronizer with rise/fall pulses; PWM_CAPTURE_GLITCH_FILTER_EN adds
// a 16-clock stability filter ahead of the edge detector.
module pwm_edge_sync (
   input  logic clk,
   input  logic rst_a_n,
   input  logic i_pwm,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;
   logic w_level;

   // Reset high so a pulse already in progress at release produces no rise.
   always_ff @(posedge clk or negedge rst_a_n) begin
      if (!rst_a_n) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= i_pwm;
         r_sync <= r_meta;
      end
   end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   logic       r_filt;
   logic [3:0] r_stable_cnt;

   always_ff @(posedge clk or negedge rst_a_n) begin
      if (!rst_a_n) begin
         r_filt       <= 1'b1;
         r_stable_cnt <= '0;
      end else if (r_sync == r_filt) begin
         r_stable_cnt <= '0;
      end else if (r_stable_cnt == 4'd15) begin
         r_filt       <= r_sync;
         r_stable_cnt <= '0;
      end else begin
         r_stable_cnt <= r_stable_cnt + 4'd1;
      end
   end

   assign w_level = r_filt;
`else
   assign w_level = r_sync;
`endif

   always_ff @(posedge clk or negedge rst_a_n) begin
      if (!rst_a_n) r_prev <= 1'b1;
      else          r_prev <= w_level;
   end

   assign o_level = w_level;
   assign o_rise  = w_level & ~r_prev;
   assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/pwm_capture.sv
// Servo-PWM decoder: measures high-pulse width and publishes a signed angle code.
// Optional input glitch filter: define PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int unsigned CENTER_CNT  = PWM_CENTER_CNT,
   parameter int unsigned STEP_CNT    = PWM_STEP_CNT,
   parameter int unsigned MIN_CNT     = PWM_MIN_CNT,
   parameter int unsigned MAX_CNT     = PWM_MAX_CNT,
   parameter int unsigned TIMEOUT_CNT = PWM_TIMEOUT_CNT
) (
   input  logic        clk,
   input  logic        rst_a_n,
   input  logic        pwm_in,
   output logic [15:0] absolute_angle,
   output logic        is_negative,
   output logic        valid,
   output logic        range_err,
   output logic        timeout
);

   localparam logic [CNT_W-1:0]   L_CENTER = CNT_W'(CENTER_CNT);
   localparam logic [CNT_W-1:0]   L_STEP   = CNT_W'(STEP_CNT);
   localparam logic [CNT_W-1:0]   L_MIN    = CNT_W'(MIN_CNT);
   localparam logic [CNT_W-1:0]   L_MAX    = CNT_W'(MAX_CNT);
   localparam logic [IDLE_W-1:0]  L_TO     = IDLE_W'(TIMEOUT_CNT);
   localparam logic [ANGLE_W-1:0] L_MAG_MAX = ANGLE_W'(128);

   logic w_level;
   logic w_rise;
   logic w_fall;

   state_t r_state;
   state_t w_next;

   logic [CNT_W-1:0]   r_width;
   logic [CNT_W-1:0]   r_diff;
   logic [ANGLE_W-1:0] r_mag;
   logic               r_neg;
   logic               r_rerr;
   logic [IDLE_W-1:0]  r_idle;

   logic [15:0] r_angle;
   logic        r_is_neg;
   logic        r_valid;
   logic        r_range;
   logic        r_timeout;

   logic               w_neg;
   logic               w_oor;
   logic [CNT_W-1:0]   w_absdiff;
   logic               w_div_done;
   logic               w_idle_hit;

   pwm_edge_sync u_edge (
      .clk     (clk),
      .rst_a_n (rst_a_n),
      .i_pwm   (pwm_in),
      .o_level (w_level),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   assign w_neg      = r_width < L_CENTER;
   assign w_absdiff  = w_neg ? (L_CENTER - r_width) : (r_width - L_CENTER);
   assign w_oor      = (r_width < L_MIN) || (r_width > L_MAX);
   assign w_div_done = r_rerr || (r_diff < L_STEP) || (r_mag == L_MAG_MAX);
   assign w_idle_hit = !w_rise && (r_idle == L_TO - IDLE_W'(1));

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_SYNC:      if (!w_level)   w_next = ST_WAIT_RISE;
         ST_WAIT_RISE: if (w_rise)     w_next = ST_HIGH;
         ST_HIGH:      if (w_fall)     w_next = ST_DIVIDE;
         ST_DIVIDE:    if (w_div_done) w_next = ST_PUBLISH;
         ST_PUBLISH:                   w_next = ST_WAIT_RISE;
         default:                      w_next = ST_SYNC;
      endcase
      if (w_idle_hit) w_next = ST_SYNC;
   end

   always_ff @(posedge clk or negedge rst_a_n) begin
      if (!rst_a_n) r_state <= ST_SYNC;
      else          r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst_a_n) begin
      if (!rst_a_n) begin
         r_idle <= '0;
      end else if (w_rise) begin
         r_idle <= '0;
      end else if (r_idle != L_TO) begin
         r_idle <= r_idle + IDLE_W'(1);
      end
   end

   // Width starts at 1 on the rise cycle so the latched value equals the high time.
   always_ff @(posedge clk or negedge rst_a_n) begin
      if (!rst_a_n) begin
         r_width <= '0;
         r_diff  <= '0;
         r_mag   <= '0;
         r_neg   <= 1'b0;
         r_rerr  <= 1'b0;
      end else begin
         case (r_state)
            ST_WAIT_RISE: if (w_rise) r_width <= CNT_W'(1);
            ST_HIGH: begin
               if (w_fall) begin
                  r_diff <= w_absdiff;
                  r_neg  <= w_neg;
                  r_rerr <= w_oor;
                  r_mag  <= w_oor ? L_MAG_MAX : '0;
               end else if (w_level && (r_width != '1)) begin
                  r_width <= r_width + CNT_W'(1);
               end
            end
            ST_DIVIDE: begin
               if (!w_div_done) begin
                  r_diff <= r_diff - L_STEP;
                  r_mag  <= r_mag + ANGLE_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_a_n) begin
      if (!rst_a_n) begin
         r_angle   <= '0;
         r_is_neg  <= 1'b0;
         r_valid   <= 1'b0;
         r_range   <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_range <= 1'b0;
         if (r_state == ST_PUBLISH) begin
            r_angle   <= {7'b0, r_mag, 1'b0};
            r_is_neg  <= r_neg && (r_mag != '0);
            r_valid   <= 1'b1;
            r_range   <= r_rerr;
            r_timeout <= 1'b0;
         end
         if (w_idle_hit) r_timeout <= 1'b1;
      end
   end

   assign absolute_angle = r_angle;
   assign is_negative    = r_is_neg;
   assign valid          = r_valid;
   assign range_err      = r_range;
   assign timeout        = r_timeout;

endmodule
